// File: rtl/bnn_inst_seq.sv
// Instruction fetch sequencer: fetches 16-bit words from the instruction SRAM and issues them to the decoder over valid/ready.
// Latency: 3 cycles per instruction (FETCH, WAIT, ISSUE). Backpressure: ISSUE holds inst_out until inst_ready.
module bnn_inst_seq #(
    parameter int          AW      = 8,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_pc,
    input  logic          abort,
    output logic          isram_en,
    output logic [AW-1:0] isram_addr,
    input  logic [15:0]   isram_rdata,
    output logic [15:0]   inst_out,
    output logic          inst_valid,
    input  logic          inst_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc,
    output logic [15:0]   issued_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic   hs;
    logic   is_halt;
    logic   pc_last;

    assign hs      = (state == S_ISSUE) && inst_valid && inst_ready;
    assign is_halt = (isram_rdata[15:11] == HALT_OP);
    assign pc_last = (pc == {AW{1'b1}});

    assign isram_en   = (state == S_FETCH);
    assign isram_addr = pc;
    assign busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_WAIT;
            S_WAIT:         state_nxt = is_halt ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                // Running off the end of the program is an error unless the decoder jumps away.
                if (hs) state_nxt = (!redirect_valid && pc_last) ? S_DONE : S_FETCH;
            end
            default:        state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            err        <= 1'b0;
            issued_cnt <= '0;
        end else begin
            // An instruction accepted in the same cycle as abort still counts.
            if (hs && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (abort) begin
                inst_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            pc         <= start_pc;
                            err        <= 1'b0;
                            issued_cnt <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (!is_halt) begin
                            inst_out   <= isram_rdata;
                            inst_valid <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (hs) begin
                            inst_valid <= 1'b0;
                            if (redirect_valid) pc  <= redirect_pc;
                            else if (pc_last)   err <= 1'b1;
                            else                pc  <= pc + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_inst_seq.sv
// Directed bench for bnn_inst_seq with a 16-word instruction SRAM model (AW=4).
module tb_bnn_inst_seq;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, inst_ready, redirect_valid;
    logic [AW-1:0] start_pc, redirect_pc;
    logic          isram_en, inst_valid, busy, done, err;
    logic [AW-1:0] isram_addr, pc;
    logic [15:0]   isram_rdata, inst_out, issued_cnt;
    logic [15:0]   mem [16];

    int checks = 0;
    int errors = 0;

    bnn_inst_seq #(.AW(AW), .HALT_OP(5'b11111)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .abort(abort),
        .isram_en(isram_en), .isram_addr(isram_addr), .isram_rdata(isram_rdata),
        .inst_out(inst_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .done(done), .err(err), .pc(pc), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (isram_en) isram_rdata <= mem[isram_addr];
    end

    typedef struct {
        logic        start;
        logic        ready;
        logic        en;
        logic        vld;
        logic [15:0] inst;
        logic [3:0]  pc;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t lin [13];

    function automatic logic [63:0] snap();
        return {19'd0, busy, done, err, inst_valid, isram_en, isram_addr, pc, inst_out, issued_cnt};
    endfunction

    function automatic logic [63:0] mk(input logic b, input logic d, input logic e, input logic v,
                                       input logic en, input logic [3:0] p, input logic [15:0] ins,
                                       input logic [15:0] cnt);
        return {19'd0, b, d, e, v, en, p, p, ins, cnt};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int exp_fetch[11] = '{3, 4, 5, 3, 4, 5, 3, 4, 5, 6, 7};
        int n5;
        int hs_cnt;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst = 1; start = 0; abort = 0; inst_ready = 0; redirect_valid = 0;
        start_pc = '0; redirect_pc = '0;
        step(); step();
        chk("reset", snap(), mk(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'd0));
        rst = 0;
        step();

        // Linear program, one vector per cycle
        mem[0] = 16'h0800; mem[1] = 16'h2001; mem[2] = 16'h3800; mem[3] = 16'hF800;
        lin[0]  = '{1, 1, 1, 0, 16'h0000, 4'd0, 16'd0, 1, 0};
        lin[1]  = '{0, 1, 0, 0, 16'h0000, 4'd0, 16'd0, 1, 0};
        lin[2]  = '{0, 1, 0, 1, 16'h0800, 4'd0, 16'd0, 1, 0};
        lin[3]  = '{0, 1, 1, 0, 16'h0800, 4'd1, 16'd1, 1, 0};
        lin[4]  = '{0, 1, 0, 0, 16'h0800, 4'd1, 16'd1, 1, 0};
        lin[5]  = '{0, 1, 0, 1, 16'h2001, 4'd1, 16'd1, 1, 0};
        lin[6]  = '{0, 1, 1, 0, 16'h2001, 4'd2, 16'd2, 1, 0};
        lin[7]  = '{0, 1, 0, 0, 16'h2001, 4'd2, 16'd2, 1, 0};
        lin[8]  = '{0, 1, 0, 1, 16'h3800, 4'd2, 16'd2, 1, 0};
        lin[9]  = '{0, 1, 1, 0, 16'h3800, 4'd3, 16'd3, 1, 0};
        lin[10] = '{0, 1, 0, 0, 16'h3800, 4'd3, 16'd3, 1, 0};
        lin[11] = '{0, 1, 0, 0, 16'h3800, 4'd3, 16'd3, 0, 1};
        lin[12] = '{0, 1, 0, 0, 16'h3800, 4'd3, 16'd3, 0, 1};
        start_pc = 4'd0;
        for (int i = 0; i < 13; i++) begin
            start = lin[i].start;
            inst_ready = lin[i].ready;
            step();
            chk($sformatf("linear[%0d]", i), snap(),
                mk(lin[i].busy, lin[i].done, 0, lin[i].vld, lin[i].en, lin[i].pc, lin[i].inst, lin[i].cnt));
        end
        start = 0;

        // Backpressure: five cycles with inst_ready low in ISSUE
        mem[0] = 16'h1234;
        inst_ready = 0; start_pc = 4'd0; start = 1;
        step(); start = 0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold[%0d]", i), snap(), mk(1, 0, 0, 1, 0, 4'd0, 16'h1234, 16'd0));
            step();
        end
        inst_ready = 1;
        step();
        chk("bp_accept", snap(), mk(1, 0, 0, 0, 1, 4'd1, 16'h1234, 16'd1));
        abort = 1;
        step(); abort = 0;
        chk("bp_abort", snap(), mk(0, 1, 0, 0, 0, 4'd1, 16'h1234, 16'd1));

        // Jump loop; redirect is also driven (to 9) outside handshakes and must be ignored
        mem[3] = 16'h1003; mem[4] = 16'h1004; mem[5] = 16'h3002; mem[6] = 16'h1006; mem[7] = 16'hF800;
        start_pc = 4'd3; inst_ready = 1; start = 1; n5 = 0;
        step(); start = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (isram_en) q.push_back(int'(isram_addr));
            if (inst_valid) begin
                redirect_valid = (pc == 4'd5) && (n5 < 2);
                redirect_pc = 4'd3;
                if (redirect_valid) n5++;
            end else begin
                redirect_valid = 1;
                redirect_pc = 4'd9;
            end
            step();
        end
        redirect_valid = 0;
        chk("jump_len", 64'(q.size()), 64'd11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("jump_fetch[%0d]", i), 64'((i < q.size()) ? q[i] : 255), 64'(exp_fetch[i]));
        chk("jump_end", snap(), mk(0, 1, 0, 0, 0, 4'd7, 16'h1006, 16'd10));

        // PC overflow at the last address
        mem[15] = 16'h0000;
        start_pc = 4'd15; start = 1; hs_cnt = 0;
        step(); start = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (inst_valid && inst_ready) hs_cnt++;
            step();
        end
        chk("ovf_hs", 64'(hs_cnt), 64'd1);
        chk("ovf_end", snap(), mk(0, 1, 1, 0, 0, 4'd15, 16'h0000, 16'd1));

        // start with abort in DONE: abort wins, nothing reloaded
        start_pc = 4'd2; start = 1; abort = 1;
        step(); start = 0; abort = 0;
        chk("start_abort", snap(), mk(0, 1, 1, 0, 0, 4'd15, 16'h0000, 16'd1));

        // Restart clears err
        mem[8] = 16'hF800;
        start_pc = 4'd8; start = 1;
        step(); start = 0;
        chk("restart_err", snap(), mk(1, 0, 0, 0, 1, 4'd8, 16'h0000, 16'd0));
        step(); step();
        chk("halt_first", snap(), mk(0, 1, 0, 0, 0, 4'd8, 16'h0000, 16'd0));

        // Abort during WAIT discards the read
        mem[0] = 16'h1111;
        start_pc = 4'd0; start = 1;
        step(); start = 0;
        step();
        abort = 1;
        step(); abort = 0;
        chk("abort_wait", snap(), mk(0, 1, 0, 0, 0, 4'd0, 16'h0000, 16'd0));
        step(); step();
        chk("abort_noissue", snap(), mk(0, 1, 0, 0, 0, 4'd0, 16'h0000, 16'd0));
        mem[8] = 16'h2222;
        start_pc = 4'd8; start = 1; inst_ready = 0;
        step(); start = 0;
        chk("abort_restart", snap(), mk(1, 0, 0, 0, 1, 4'd8, 16'h0000, 16'd0));
        step(); step();
        chk("restart_issue", snap(), mk(1, 0, 0, 1, 0, 4'd8, 16'h2222, 16'd0));

        // Reset mid-ISSUE overrides start and abort
        rst = 1; start = 1; abort = 1; inst_ready = 1;
        step();
        chk("rst_issue", snap(), mk(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'd0));
        rst = 0; start = 0; abort = 0;
        step();
        chk("rst_idle", snap(), mk(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_inst_seq.md
Name: bnn_inst_seq

Overview:
Instruction fetch sequencer for the BNN controller. It reads 16-bit instructions from the instruction SRAM and holds a program counter. It presents one instruction at a time to the BPU decoder through a valid/ready handshake. It applies jump redirects returned by the decoder and stops the program on HALT, on a PC overflow, or on an external abort.

Parameters:
AW, 8, instruction SRAM address width; program depth is 2^AW words
HALT_OP, 5'b11111, opcode in inst[15:11] that ends the program; a HALT word is never issued

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a program at start_pc; honoured only in IDLE or DONE
start_pc  in  AW  first fetch address
abort  in  1  synchronous stop request; any state goes to DONE next cycle
isram_en  out  1  instruction SRAM read enable
isram_addr  out  AW  instruction SRAM read address
isram_rdata  in  16  read data, valid the cycle after isram_en
inst_out  out  16  instruction presented to the decoder
inst_valid  out  1  inst_out is valid
inst_ready  in  1  decoder accepts inst_out
redirect_valid  in  1  decoder requests a jump; sampled only on a handshake cycle
redirect_pc  in  AW  jump target
busy  out  1  state is not IDLE and not DONE
done  out  1  state is DONE
err  out  1  sticky; set by PC overflow; cleared by start or rst
pc  out  AW  current program counter
issued_cnt  out  16  instructions accepted since start; saturates at 16'hFFFF

Behaviour:
- Reset: state IDLE, pc=0, inst_out=0, inst_valid=0, isram_en=0, isram_addr=0, busy=0, done=0, err=0, issued_cnt=0.
- The synchronous reset overrides every input, including during a mid-program fetch or issue.
- States: IDLE, FETCH, WAIT, ISSUE, DONE.
- IDLE/DONE + start:
  - pc<=start_pc, err<=0, issued_cnt<=0.
  - Next state is FETCH.
- FETCH (one cycle):
  - isram_en=1, isram_addr=pc (combinational from pc).
  - Next state is WAIT.
- WAIT (one cycle):
  - Capture isram_rdata.
  - If rdata[15:11]==HALT_OP: go to DONE; pc holds the HALT address; nothing is issued.
  - Otherwise: inst_out<=rdata, inst_valid<=1, go to ISSUE.
- ISSUE:
  - inst_valid=1; inst_out is held stable until the handshake (inst_valid && inst_ready).
  - On handshake:
    - inst_valid<=0; issued_cnt increments.
    - If redirect_valid: pc<=redirect_pc.
    - Else if pc == 2^AW-1: err<=1, go to DONE (no wrap).
    - Else pc<=pc+1.
    - Next state is FETCH unless overflow.
- Issue rate: one instruction per 3 cycles when inst_ready is held high (FETCH, WAIT, ISSUE).
- redirect_valid outside a handshake cycle is ignored.
- A redirect on the instruction at address 2^AW-1 is legal and does not set err.
- abort:
  - Has priority over everything except rst.
  - Any state goes to DONE next cycle; inst_valid<=0; an in-flight read is discarded.
  - pc and issued_cnt hold.
  - abort in a handshake cycle: the instruction counts as accepted (issued_cnt increments) but pc does not advance.
- start while busy is ignored.
- start and abort together in IDLE/DONE: abort wins; state stays/enters DONE; pc, err and issued_cnt are not reloaded.
- DONE holds done=1 until start or rst. It does not return to IDLE on its own.
- isram_en is high only in FETCH.

Test Plan:
- Linear program: SRAM[0..3]={16'h0800,16'h2001,16'h3800,16'hF800}, start_pc=0, inst_ready=1 -> three handshakes with inst_out 0800, 2001, 3800, 3 cycles apart; done=1 with pc=3, issued_cnt=3, err=0; 16'hF800 is never issued.
- Backpressure: inst_ready low for 5 cycles in ISSUE -> inst_valid stays 1, inst_out is unchanged, pc does not move; the handshake occurs on the first cycle inst_ready=1.
- Jump loop: SRAM[5]=16'h3002, redirect_valid=1 with redirect_pc=3 on the first two handshakes of address 5, then redirect_valid=0 -> fetch order 3,4,5,3,4,5,3,4,5,6.
- Overflow: AW=4, start_pc=15, SRAM[15]=16'h0000 -> one handshake, then err=1, done=1, pc=15; a later start clears err.
- Abort mid-WAIT, then start_pc=8 -> done=1 next cycle, no issue; the restart fetches address 8 with issued_cnt=0.
- Reset mid-ISSUE with inst_valid=1 -> the next cycle shows every reset value; start and abort asserted in the same cycle as rst have no effect.
